// File: rtl/hack_loader_pkg.sv
// Shared types and constants for the Hack boot-time program loader.
// Image layout: count_hi, count_lo, N x (word_hi, word_lo), checksum byte.
package hack_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 16;
    localparam int COUNT_W    = 16;
    localparam int HDR_BYTES  = 2;
    localparam int CSUM_BYTES = 1;

    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_WORD_HI,
        ST_WORD_LO,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } state_t;

    // Total byte transfers making up an image of n words.
    function automatic int unsigned image_bytes(input int unsigned n);
        return HDR_BYTES + 2 * n + CSUM_BYTES;
    endfunction

endpackage

// File: rtl/hack_loader_word_asm.sv
// Assembles instruction words from byte pairs and issues one registered
// instruction-memory write per word at consecutive addresses.
module hack_loader_word_asm
    import hack_loader_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              hi_load,
    input  logic              lo_load,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_data,
    output logic [ADDR_W:0]   index
);

    logic [BYTE_W-1:0] hi_q;

    // One extra index bit so a full 2^ADDR_W image ends at 2^ADDR_W without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q      <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
            index     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            imem_we <= lo_load;
            if (clear) begin
                index <= '0;
            end else begin
                if (hi_load) hi_q <= byte_data;
                if (lo_load) begin
                    imem_addr <= index[ADDR_W-1:0];
                    imem_data <= {hi_q, byte_data};
                    index     <= index + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: rtl/hack_program_loader.sv
// Boot controller: holds the Hack CPU in reset, streams an image into
// instruction memory, checks the XOR checksum, then releases the CPU.
module hack_program_loader
    import hack_loader_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_data_i,
    output logic              byte_ready_o,
    input  logic              reload_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [WORD_W-1:0] imem_data_o,
    output logic              cpu_reset_o,
    output logic              done_o,
    output logic              error_o
);

    state_t               state, next_state;
    logic                 armed;
    logic [BYTE_W-1:0]    acc;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   n_word;
    logic [ADDR_W:0]      index;
    logic                 xfer, too_big, last_word, csum_ok;
    logic                 run_d, err_d;

    // A reload discards any byte offered in the same cycle.
    assign xfer      = byte_valid_i && byte_ready_o && !reload_i;
    assign n_word    = {count_q[COUNT_W-1:BYTE_W], byte_data_i};
    assign too_big   = 32'(n_word) > (32'd1 << ADDR_W);
    assign last_word = (32'(index) + 32'd1) == 32'(count_q);
    assign csum_ok   = byte_data_i == acc;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= ST_HDR_HI;
            armed <= 1'b0;
        end else begin
            state <= next_state;
            armed <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        next_state = state;
        if (reload_i) begin
            next_state = ST_HDR_HI;
        end else if (xfer) begin
            unique case (state)
                ST_HDR_HI:  next_state = ST_HDR_LO;
                ST_HDR_LO:  next_state = (n_word == '0) ? ST_CSUM :
                                         too_big        ? ST_ERROR : ST_WORD_HI;
                ST_WORD_HI: next_state = ST_WORD_LO;
                ST_WORD_LO: next_state = last_word ? ST_CSUM : ST_WORD_HI;
                ST_CSUM:    next_state = csum_ok ? ST_RUN : ST_ERROR;
                default:    next_state = state;
            endcase
        end
    end

    // Ready stays low until the first clock after reset release.
    always_comb begin
        byte_ready_o = armed && (state inside {ST_HDR_HI, ST_HDR_LO, ST_WORD_HI,
                                               ST_WORD_LO, ST_CSUM});
        run_d        = next_state == ST_RUN;
        err_d        = next_state == ST_ERROR;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cpu_reset_o <= 1'b1;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            acc         <= '0;
            count_q     <= '0;
        end else begin
            cpu_reset_o <= !run_d;
            done_o      <= run_d;
            error_o     <= err_d;
            if (reload_i) begin
                acc <= '0;
            end else if (xfer) begin
                if (state != ST_CSUM) acc <= acc ^ byte_data_i;
                if (state == ST_HDR_HI) count_q[COUNT_W-1:BYTE_W] <= byte_data_i;
                if (state == ST_HDR_LO) count_q <= n_word;
            end
        end
    end

    hack_loader_word_asm #(.ADDR_W(ADDR_W)) u_word_asm (
        .clk       (clk_i),
        .rst_n     (reset_ni),
        .clear     (reload_i),
        .hi_load   (xfer && state == ST_WORD_HI),
        .lo_load   (xfer && state == ST_WORD_LO),
        .byte_data (byte_data_i),
        .imem_we   (imem_we_o),
        .imem_addr (imem_addr_o),
        .imem_data (imem_data_o),
        .index     (index)
    );

endmodule

// File: tb/tb_hack_program_loader.sv
// Self-checking bench for hack_program_loader: table-driven images plus
// hand-written reload/reset sequences, with a write scoreboard.
module tb_hack_program_loader;
    import hack_loader_pkg::*;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset_ni = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              reload = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;
    logic              cpu_reset, done, error;

    hack_program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .reload_i     (reload),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_data_o  (imem_data),
        .cpu_reset_o  (cpu_reset),
        .done_o       (done),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int xfers    = 0;
    int we_pulses = 0;
    logic prev_we = 1'b0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [15:0] n;
        logic [15:0] w0;
        logic [15:0] w1;
        bit          corrupt;
        bit          gaps;
        bit          exp_done;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [15:0] w0, input logic [15:0] w1, input int i);
        if (i == 0) return w0;
        if (i == 1) return w1;
        return w0 ^ 16'(i * 15451);
    endfunction

    // Scoreboard: every write strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (reset_ni && imem_we) begin
            we_pulses++;
            check("we_single_cycle", {31'b0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'b0, imem_we}, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", 32'(imem_data), 32'(e.data));
            end
        end
        prev_we = imem_we;
    end

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) check("ready_timeout", {31'b0, byte_ready}, 32'd1);
        @(negedge clk);
        xfers++;
    endtask

    task automatic send_image(input logic [15:0] n, input logic [15:0] w0, input logic [15:0] w1,
                              input bit corrupt, input bit gaps);
        logic [7:0]  acc;
        logic [15:0] w;
        int          x0;
        acc = '0;
        x0  = xfers;
        send_byte(n[15:8], gaps); acc ^= n[15:8];
        send_byte(n[7:0], gaps);  acc ^= n[7:0];
        for (int i = 0; i < int'(n); i++) begin
            w = word_of(w0, w1, i);
            send_byte(w[15:8], gaps); acc ^= w[15:8];
            exp_q.push_back('{addr: ADDR_W'(i), data: w});
            send_byte(w[7:0], gaps);  acc ^= w[7:0];
        end
        check("pre_csum_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("pre_csum_done", {31'b0, done}, 32'd0);
        send_byte(acc ^ {7'b0, corrupt}, gaps);
        byte_valid = 1'b0;
        check("xfer_count", 32'(xfers - x0), 32'(image_bytes(32'(n))));
    endtask

    task automatic reload_pulse();
        reload = 1'b1;
        @(negedge clk);
        reload     = 1'b0;
        byte_valid = 1'b0;
        check("reload_ready", {31'b0, byte_ready}, 32'd1);
        check("reload_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("reload_done", {31'b0, done}, 32'd0);
        check("reload_error", {31'b0, error}, 32'd0);
    endtask

    task automatic check_final(input bit exp_done);
        check("final_done", {31'b0, done}, {31'b0, exp_done});
        check("final_error", {31'b0, error}, {31'b0, !exp_done});
        check("final_cpu_reset", {31'b0, cpu_reset}, {31'b0, !exp_done});
        check("final_ready", {31'b0, byte_ready}, 32'd0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_ready", {31'b0, byte_ready}, 32'd0);
        check("rst_we", {31'b0, imem_we}, 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_data", 32'(imem_data), 32'd0);
        check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   p0;
        vecs[0] = '{n: 16'd2,  w0: 16'h0010, w1: 16'hEC10, corrupt: 1'b0, gaps: 1'b0, exp_done: 1'b1};
        vecs[1] = '{n: 16'd2,  w0: 16'h0010, w1: 16'hEC10, corrupt: 1'b1, gaps: 1'b0, exp_done: 1'b0};
        vecs[2] = '{n: 16'd0,  w0: 16'h0000, w1: 16'h0000, corrupt: 1'b0, gaps: 1'b0, exp_done: 1'b1};
        vecs[3] = '{n: 16'd16, w0: 16'h1234, w1: 16'hBEEF, corrupt: 1'b0, gaps: 1'b1, exp_done: 1'b1};
        vecs[4] = '{n: 16'd16, w0: 16'h1234, w1: 16'hBEEF, corrupt: 1'b0, gaps: 1'b0, exp_done: 1'b1};
        vecs[5] = '{n: 16'd5,  w0: 16'hA5A5, w1: 16'h0001, corrupt: 1'b0, gaps: 1'b1, exp_done: 1'b1};

        #12;
        check_reset_values();
        #11 reset_ni = 1'b1;
        #1 check("ready_before_first_clk", {31'b0, byte_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_release", {31'b0, byte_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            if (i != 0) reload_pulse();
            p0 = we_pulses;
            send_image(vecs[i].n, vecs[i].w0, vecs[i].w1, vecs[i].corrupt, vecs[i].gaps);
            check_final(vecs[i].exp_done);
            check("we_pulse_count", 32'(we_pulses - p0), 32'(vecs[i].n));
            if (!vecs[i].exp_done) begin
                // Bytes offered while rejected must be ignored.
                byte_valid = 1'b1;
                byte_data  = 8'h5A;
                repeat (3) @(negedge clk);
                byte_valid = 1'b0;
                check("error_sticky", {31'b0, error}, 32'd1);
                check("error_ready", {31'b0, byte_ready}, 32'd0);
            end
        end

        // Oversized count is rejected right after count_lo.
        reload_pulse();
        send_byte(8'h80, 1'b0);
        send_byte(8'h01, 1'b0);
        byte_valid = 1'b0;
        check("oversize_error", {31'b0, error}, 32'd1);
        check("oversize_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("oversize_ready", {31'b0, byte_ready}, 32'd0);

        // Reload coincident with a WORD_LO transfer discards that word.
        reload_pulse();
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h11, 1'b0);
        exp_q.push_back('{addr: ADDR_W'(0), data: 16'h1122});
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        byte_data  = 8'h44;
        byte_valid = 1'b1;
        reload_pulse();
        @(negedge clk);
        check("reload_no_write", 32'(exp_q.size()), 32'd0);
        send_image(16'd3, 16'hC0DE, 16'h7777, 1'b0, 1'b0);
        check_final(1'b1);

        // Asynchronous reset mid-image, then a full reload.
        reload_pulse();
        send_byte(8'h00, 1'b0);
        send_byte(8'h08, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hF0 + 8'(i), 1'b0);
            exp_q.push_back('{addr: ADDR_W'(i), data: {8'hF0 + 8'(i), 8'(i)}});
            send_byte(8'(i), 1'b0);
        end
        byte_valid = 1'b0;
        #2 reset_ni = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        #2 reset_ni = 1'b1;
        @(negedge clk);
        check("ready_after_midreset", {31'b0, byte_ready}, 32'd1);
        send_image(16'd4, 16'h0F0F, 16'hF00D, 1'b0, 1'b0);
        check_final(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
